sprite_addr_gen: RTL and testbench
==================================

Name: sprite_addr_gen

Overview:
- Parametrised multi-sprite ROM address generator for collectible sprites such as bananas. Replaces fixed per-sprite address outputs with a run-time-loaded position table, a single muxed address output with hit and id, a built-in animation frame counter, and per-sprite collected/hidden state.
- Sits between the scroll/draw-coordinate logic and the sprite ROM and colour mapper. The output is registered, with 1-cycle latency from DrawX/DrawY.

Parameters:
- NUM_SPRITES, 5, number of sprite slots (1..16).
- SPRITE_W, 32, sprite width in pixels (power of two).
- SPRITE_H, 32, sprite height in pixels (power of two).
- FRAMES, 8, animation frames stored consecutively in ROM (power of two).
- FRAME_DIV, 4, frame_clk rising edges per animation step (>=1).
- ADDR_W, 19, ROM address width.
- RESPAWN_TICKS, 600, frame_clk rising edges before respawn (used only with the optional feature).

Ports:
- Clk, input, 1, system clock.
- Reset, input, 1, asynchronous active-high reset.
- frame_clk, input, 1, vsync-rate pulse; synchronous to Clk, edge-detected internally.
- scroll_x, input, 16, world X of screen column 0.
- DrawX, input, 10, current pixel X.
- DrawY, input, 10, current pixel Y.
- pos_we, input, 1, write position table entry.
- pos_idx, input, 4, slot index for pos_we.
- pos_x, input, 16, world X of the sprite's top-left corner.
- pos_y, input, 10, screen Y of the sprite's top-left corner.
- collect_valid, input, 1, mark slot collected.
- collect_idx, input, 4, slot index for collect_valid.
- sprite_addr, output, ADDR_W, ROM address for the winning sprite.
- sprite_hit, output, 1, the pixel lies inside a visible sprite.
- sprite_id, output, 4, index of the winning sprite.
- anim_frame, output, log2(FRAMES), current animation frame.

Behaviour:
- Reset (asynchronous, active-high):
  - All valid and collected bits = 0; all positions = 0.
  - Frame divider = 0; anim_frame = 0; edge-detect register = 0.
  - sprite_addr = 0, sprite_hit = 0, sprite_id = 0.
  - Reset mid-frame takes effect immediately. No sprite is drawn until it is written after reset.
- Animation:
  - frame_tick = frame_clk & ~frame_clk_q.
  - On each tick the divider increments. When it reaches FRAME_DIV-1 it clears and anim_frame increments modulo FRAMES (FRAMES-1 wraps to 0).
- Position write:
  - pos_we with pos_idx < NUM_SPRITES stores pos_x/pos_y, sets valid=1 and clears collected.
  - pos_idx >= NUM_SPRITES is ignored.
- Collect:
  - collect_valid with idx < NUM_SPRITES and valid=1 sets collected=1; otherwise it is ignored.
  - If pos_we and collect_valid target the same idx in the same cycle, pos_we wins: the slot ends valid=1, collected=0.
- Hit test, per slot i, combinational, then registered:
  - wx = {1'b0,scroll_x} + DrawX, 17-bit, no truncation.
  - dx = wx - pos_x[i]; dy = DrawY - pos_y[i]; both unsigned with borrow.
  - inside_i = valid & ~collected & no borrow on dx and dy & dx < SPRITE_W & dy < SPRITE_H.
- Priority: the lowest index with inside_i wins.
- Address: sprite_addr = dx + dy*SPRITE_W + anim_frame*SPRITE_W*SPRITE_H, truncated to ADDR_W.
- Output registration:
  - Registered outputs update every Clk. Latency is 1 cycle after DrawX/DrawY/scroll_x.
  - With no hit: sprite_hit=0, sprite_addr=0, sprite_id=0.
- Position-table and collected changes affect the hit test starting the cycle after the write.
- Boundaries:
  - dx = SPRITE_W-1 and dy = SPRITE_H-1 are inside; SPRITE_W or SPRITE_H is outside.
  - A sprite with pos_x > wx produces a borrow, so it is a miss (no aliasing).

Optional Feature:
- Macro: SPRITE_RESPAWN_EN.
- When defined:
  - Each slot has a respawn counter, cleared when the slot becomes collected.
  - The counter increments on frame_tick while collected.
  - On reaching RESPAWN_TICKS-1 it clears collected, and the sprite redraws from the next cycle.
  - A pos_we to the slot clears its counter.
- When undefined: no counters exist; collected persists until pos_we to that slot or Reset.

Test Plan:
- Reset, then write slot 0 at (943,100) with scroll_x=0. DrawX=943, DrawY=100 -> next cycle hit=1, id=0, addr=0. DrawX=974, DrawY=131 -> addr=1023.
- Slot 0 at (943,100) with scroll_x=900. DrawX=44, DrawY=101 -> addr=33. DrawX=75 (dx=32) -> hit=0, addr=0.
- Slots 1 and 3 both at (200,50), scroll 0, pixel (205,52) -> id=1, addr=69. Collect slot 1 -> id=3.
- 8 frame_clk pulses (FRAME_DIV=4) -> anim_frame=2; pixel (200,50) on slot 1 -> addr=2048. 32 pulses from reset -> anim_frame wraps to 0.
- Same-cycle pos_we and collect_valid to slot 2 -> slot 2 drawn. collect_idx=9 -> no state change.
- SPRITE_RESPAWN_EN with RESPAWN_TICKS=3: collect slot 0, then 3 ticks -> hit reappears. Without the macro: still hidden after 1000 ticks.

Source files
------------

// File: rtl/sprite_addr_gen_if.sv
// Pixel/scroll inputs, position-table and collect controls, and the registered
// sprite lookup result. The master drives the controls and the slave returns the lookup.
interface sprite_addr_gen_if #(
  parameter int ADDR_W  = 19,
  parameter int FRAME_W = 3
);
  logic              frame_clk;
  logic [15:0]       scroll_x;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              pos_we;
  logic [3:0]        pos_idx;
  logic [15:0]       pos_x;
  logic [9:0]        pos_y;
  logic              collect_valid;
  logic [3:0]        collect_idx;
  logic [ADDR_W-1:0] sprite_addr;
  logic              sprite_hit;
  logic [3:0]        sprite_id;
  logic [FRAME_W-1:0] anim_frame;

  modport master (
    output frame_clk, scroll_x, DrawX, DrawY, pos_we, pos_idx, pos_x, pos_y,
           collect_valid, collect_idx,
    input  sprite_addr, sprite_hit, sprite_id, anim_frame
  );

  modport slave (
    input  frame_clk, scroll_x, DrawX, DrawY, pos_we, pos_idx, pos_x, pos_y,
           collect_valid, collect_idx,
    output sprite_addr, sprite_hit, sprite_id, anim_frame
  );
endinterface

// File: rtl/sprite_addr_gen.sv
// Multi-slot sprite ROM address generator: 1-cycle registered lookup, no backpressure.
// SPRITE_RESPAWN_EN adds per-slot respawn timers that un-collect a sprite after RESPAWN_TICKS.
module sprite_addr_gen #(
  parameter int NUM_SPRITES   = 5,
  parameter int SPRITE_W      = 32,
  parameter int SPRITE_H      = 32,
  parameter int FRAMES        = 8,
  parameter int FRAME_DIV     = 4,
  parameter int ADDR_W        = 19,
  parameter int RESPAWN_TICKS = 600
) (
  input  logic             Clk,
  input  logic             Reset,
  sprite_addr_gen_if.slave bus
);
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FRAME_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

  if (NUM_SPRITES < 1 || NUM_SPRITES > 16 || FRAME_DIV < 1 || RESPAWN_TICKS < 1) begin : g_bad_params
    $error("sprite_addr_gen: parameter out of range");
  end

  logic                   r_frame_clk_q;
  logic [DIV_W-1:0]       r_div;
  logic [FRAME_W-1:0]     r_anim;
  logic [NUM_SPRITES-1:0] r_valid;
  logic [NUM_SPRITES-1:0] r_coll;
  logic [15:0]            r_pos_x [NUM_SPRITES];
  logic [9:0]             r_pos_y [NUM_SPRITES];
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_hit;
  logic [3:0]             r_id;

  logic                   w_tick;
  logic [NUM_SPRITES-1:0] w_pos_sel;
  logic [NUM_SPRITES-1:0] w_col_sel;
  logic [NUM_SPRITES-1:0] w_respawn;
  logic [NUM_SPRITES-1:0] w_inside;
  logic [16:0]            w_wx;
  logic [17:0]            w_dx [NUM_SPRITES];
  logic [10:0]            w_dy [NUM_SPRITES];
  logic                   w_hit;
  logic [3:0]             w_id;
  logic [16:0]            w_dx_sel;
  logic [9:0]             w_dy_sel;
  logic [ADDR_W-1:0]      w_addr;

  assign w_tick = bus.frame_clk & ~r_frame_clk_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_frame_clk_q <= 1'b0;
      r_div         <= '0;
      r_anim        <= '0;
    end else begin
      r_frame_clk_q <= bus.frame_clk;
      if (w_tick) begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_anim <= (r_anim == FRAME_LAST) ? '0 : r_anim + 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  // Out-of-range indices never match any slot, so they are dropped here.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_pos_sel[i] = bus.pos_we & (bus.pos_idx == 4'(i));
      w_col_sel[i] = bus.collect_valid & (bus.collect_idx == 4'(i)) & r_valid[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid <= '0;
      r_coll  <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_pos_x[i] <= '0;
        r_pos_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (w_pos_sel[i]) begin
          r_pos_x[i] <= bus.pos_x;
          r_pos_y[i] <= bus.pos_y;
          r_valid[i] <= 1'b1;
          r_coll[i]  <= 1'b0;
        end else if (w_col_sel[i]) begin
          r_coll[i] <= 1'b1;
        end else if (w_respawn[i]) begin
          r_coll[i] <= 1'b0;
        end
      end
    end
  end

`ifdef SPRITE_RESPAWN_EN
  localparam int RESP_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
  localparam logic [RESP_W-1:0] RESP_LAST = RESP_W'(RESPAWN_TICKS - 1);

  logic [RESP_W-1:0] r_resp_cnt [NUM_SPRITES];

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_respawn[i] = r_coll[i] & w_tick & (r_resp_cnt[i] == RESP_LAST);
    end
  end

  // Counter idles at zero while visible, so it starts fresh on every collect.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) r_resp_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (w_pos_sel[i] || !r_coll[i] || w_respawn[i]) begin
          r_resp_cnt[i] <= '0;
        end else if (w_tick) begin
          r_resp_cnt[i] <= r_resp_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign w_respawn = '0;
`endif

  assign w_wx = {1'b0, bus.scroll_x} + {7'b0, bus.DrawX};

  // The extra top bit of each difference is the borrow: sprite lies right of / below the pixel.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_dx[i]     = {1'b0, w_wx} - {2'b0, r_pos_x[i]};
      w_dy[i]     = {1'b0, bus.DrawY} - {1'b0, r_pos_y[i]};
      w_inside[i] = r_valid[i] & ~r_coll[i] & ~w_dx[i][17] & ~w_dy[i][10] &
                    (w_dx[i][16:0] < 17'(SPRITE_W)) & (w_dy[i][9:0] < 10'(SPRITE_H));
    end
  end

  always_comb begin
    w_hit    = 1'b0;
    w_id     = '0;
    w_dx_sel = '0;
    w_dy_sel = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_inside[i]) begin
        w_hit    = 1'b1;
        w_id     = 4'(i);
        w_dx_sel = w_dx[i][16:0];
        w_dy_sel = w_dy[i][9:0];
      end
    end
    w_addr = ADDR_W'(w_dx_sel) + ADDR_W'(w_dy_sel) * ADDR_W'(SPRITE_W) +
             ADDR_W'(r_anim) * ADDR_W'(SPRITE_W * SPRITE_H);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_addr <= '0;
      r_hit  <= 1'b0;
      r_id   <= '0;
    end else begin
      r_hit  <= w_hit;
      r_id   <= w_hit ? w_id : 4'd0;
      r_addr <= w_hit ? w_addr : '0;
    end
  end

  assign bus.sprite_addr = r_addr;
  assign bus.sprite_hit  = r_hit;
  assign bus.sprite_id   = r_id;
  assign bus.anim_frame  = r_anim;
endmodule

// File: tb/tb_sprite_addr_gen.sv
// Scoreboard bench for sprite_addr_gen: expected lookups are queued as pixels are driven
// and compared one cycle later; table/animation state is tracked by a small reference model.
module tb_sprite_addr_gen;
  localparam int NS = 5, SW = 32, SH = 32, NFR = 8, FDIV = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sprite_addr_gen_if #(.ADDR_W(19), .FRAME_W(3)) bus ();
  sprite_addr_gen #(.RESPAWN_TICKS(3)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef struct { logic hit; logic [3:0] id; logic [18:0] addr; } exp_t;
  typedef struct { int x; int y; int sx; exp_t e; } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bit m_valid [NS];
  bit m_coll  [NS];
  int m_x     [NS];
  int m_y     [NS];
  int m_ticks;

  function automatic exp_t mk_exp(bit hit, int id, int addr);
    exp_t e;
    e.hit = hit; e.id = 4'(id); e.addr = 19'(addr);
    return e;
  endfunction

  function automatic vec_t mk(int x, int y, int sx, bit hit, int id, int addr);
    vec_t v;
    v.x = x; v.y = y; v.sx = sx; v.e = mk_exp(hit, id, addr);
    return v;
  endfunction

  function automatic exp_t predict(int x, int y, int sx);
    exp_t e = mk_exp(1'b0, 0, 0);
    for (int i = 0; i < NS; i++) begin
      int dx = sx + x - m_x[i];
      int dy = y - m_y[i];
      if (!e.hit && m_valid[i] && !m_coll[i] && dx >= 0 && dx < SW && dy >= 0 && dy < SH)
        e = mk_exp(1'b1, i, dx + dy * SW + ((m_ticks / FDIV) % NFR) * SW * SH);
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_coll[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_ticks = 0;
  endtask

  task automatic idle_inputs();
    bus.frame_clk = 0; bus.scroll_x = '0; bus.DrawX = '0; bus.DrawY = '0;
    bus.pos_we = 0; bus.pos_idx = '0; bus.pos_x = '0; bus.pos_y = '0;
    bus.collect_valid = 0; bus.collect_idx = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic wr(input int idx, input int x, input int y);
    @(negedge Clk);
    bus.pos_we = 1; bus.pos_idx = 4'(idx); bus.pos_x = 16'(x); bus.pos_y = 10'(y);
    @(posedge Clk); #1;
    bus.pos_we = 0;
    if (idx < NS) begin
      m_valid[idx] = 1; m_coll[idx] = 0; m_x[idx] = x; m_y[idx] = y;
    end
  endtask

  task automatic collect(input int idx);
    @(negedge Clk);
    bus.collect_valid = 1; bus.collect_idx = 4'(idx);
    @(posedge Clk); #1;
    bus.collect_valid = 0;
    if (idx < NS && m_valid[idx]) m_coll[idx] = 1;
  endtask

  task automatic tick();
    @(negedge Clk);
    bus.frame_clk = 1;
    @(negedge Clk);
    bus.frame_clk = 0;
    m_ticks++;
  endtask

  task automatic drive_px(input int x, input int y, input int sx);
    @(negedge Clk);
    bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.scroll_x = 16'(sx);
  endtask

  task automatic test_reset();
    exp_t e;
    Reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge Clk);
    n_cmp++;
    if (bus.sprite_hit !== 1'b0 || bus.sprite_id !== 4'd0 || bus.sprite_addr !== 19'd0 || bus.anim_frame !== 3'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got hit=%b id=%0d addr=%0d frame=%0d, want all 0",
               bus.sprite_hit, bus.sprite_id, bus.sprite_addr, bus.anim_frame);
    end
    Reset = 1'b0;
    model_reset();
    drive_px(0, 0, 0);
    sb.push_back(mk_exp(1'b0, 0, 0));
    @(posedge Clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
      n_err++;
      $display("FAIL reset_no_sprite: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
               bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
    end
  endtask

  task automatic test_single_sprite();
    vec_t v[$];
    exp_t e;
    do_reset();
    wr(0, 943, 100);
    v.push_back(mk(943, 100, 0, 1, 0, 0));
    v.push_back(mk(974, 131, 0, 1, 0, 1023));
    v.push_back(mk(975, 131, 0, 0, 0, 0));
    v.push_back(mk(974, 132, 0, 0, 0, 0));
    v.push_back(mk(942, 100, 0, 0, 0, 0));
    v.push_back(mk(943,  99, 0, 0, 0, 0));
    v.push_back(mk(950, 110, 0, 1, 0, 327));
    foreach (v[k]) begin
      drive_px(v[k].x, v[k].y, v[k].sx);
      sb.push_back(v[k].e);
      @(posedge Clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
        n_err++;
        $display("FAIL single[%0d]: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
                 k, bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
      end
    end
  endtask

  task automatic test_scroll();
    vec_t v[$];
    exp_t e;
    do_reset();
    wr(0, 943, 100);
    wr(3, 2, 0);
    wr(4, 65530, 0);
    v.push_back(mk(44, 101, 900, 1, 0, 33));
    v.push_back(mk(75, 101, 900, 0, 0, 0));
    v.push_back(mk(43, 100, 900, 1, 0, 0));
    v.push_back(mk(74, 131, 900, 1, 0, 1023));
    v.push_back(mk(5, 0, 65535, 1, 4, 10));
    v.push_back(mk(5, 0, 0, 1, 3, 3));
    foreach (v[k]) begin
      drive_px(v[k].x, v[k].y, v[k].sx);
      sb.push_back(v[k].e);
      @(posedge Clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
        n_err++;
        $display("FAIL scroll[%0d]: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
                 k, bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
      end
    end
  endtask

  task automatic test_priority_collect();
    exp_t e;
    vec_t v;
    do_reset();
    wr(1, 200, 50);
    wr(3, 200, 50);
    for (int step = 0; step < 6; step++) begin
      case (step)
        0: v = mk(205, 52, 0, 1, 1, 69);
        1: begin collect(1); v = mk(205, 52, 0, 1, 3, 69); end
        2: begin collect(9); v = mk(205, 52, 0, 1, 3, 69); end
        3: begin wr(9, 0, 0); v = mk(0, 0, 0, 0, 0, 0); end
        4: begin wr(5, 0, 0); v = mk(0, 0, 0, 0, 0, 0); end
        default: begin
          @(negedge Clk);
          bus.pos_we = 1; bus.pos_idx = 4'd2; bus.pos_x = 16'd300; bus.pos_y = 10'd60;
          bus.collect_valid = 1; bus.collect_idx = 4'd2;
          @(posedge Clk); #1;
          bus.pos_we = 0; bus.collect_valid = 0;
          v = mk(300, 60, 0, 1, 2, 0);
        end
      endcase
      drive_px(v.x, v.y, v.sx);
      sb.push_back(v.e);
      @(posedge Clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
        n_err++;
        $display("FAIL priority[%0d]: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
                 step, bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
      end
    end
  endtask

  task automatic test_anim();
    exp_t e;
    vec_t v;
    int   want_frame;
    do_reset();
    wr(1, 200, 50);
    for (int step = 0; step < 4; step++) begin
      case (step)
        0: begin repeat (8) tick(); want_frame = 2; v = mk(200, 50, 0, 1, 1, 2048); end
        1: begin
          @(negedge Clk); bus.frame_clk = 1;
          repeat (4) @(negedge Clk);
          bus.frame_clk = 0; m_ticks++;
          want_frame = 2; v = mk(231, 81, 0, 1, 1, 3071);
        end
        2: begin repeat (22) tick(); want_frame = 7; v = mk(231, 81, 0, 1, 1, 8191); end
        default: begin tick(); want_frame = 0; v = mk(200, 50, 0, 1, 1, 0); end
      endcase
      n_cmp++;
      if (bus.anim_frame !== 3'(want_frame)) begin
        n_err++;
        $display("FAIL anim_frame[%0d]: got %0d, want %0d", step, bus.anim_frame, want_frame);
      end
      drive_px(v.x, v.y, v.sx);
      sb.push_back(v.e);
      @(posedge Clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
        n_err++;
        $display("FAIL anim_addr[%0d]: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
                 step, bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    do_reset();
    // Write and pixel land in the same cycle: old table applies, new one the cycle after.
    @(negedge Clk);
    bus.pos_we = 1; bus.pos_idx = 4'd0; bus.pos_x = 16'd10; bus.pos_y = 10'd10;
    bus.DrawX = 10'd10; bus.DrawY = 10'd10; bus.scroll_x = '0;
    sb.push_back(mk_exp(1'b0, 0, 0));
    v.push_back(mk(10, 10, 0, 1, 0, 0));
    v.push_back(mk(100, 100, 0, 0, 0, 0));
    v.push_back(mk(41, 41, 0, 1, 0, 1023));
    v.push_back(mk(42, 10, 0, 0, 0, 0));
    v.push_back(mk(11, 12, 0, 1, 0, 65));
    for (int k = 0; k <= v.size(); k++) begin
      @(posedge Clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
                 k, bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
      end
      bus.pos_we = 0;
      if (k < v.size()) begin
        drive_px(v[k].x, v[k].y, v[k].sx);
        sb.push_back(v[k].e);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   r, x, y, sx;
    do_reset();
    for (int i = 0; i < NS; i++) wr(i, 100 + $urandom_range(0, 120), 40 + $urandom_range(0, 60));
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 6) wr($urandom_range(0, 15), 100 + $urandom_range(0, 120), 40 + $urandom_range(0, 60));
      else if (r < 10) collect($urandom_range(0, 15));
      else if (r < 16) tick();
      else begin
        sx = $urandom_range(0, 40);
        x  = 60 + $urandom_range(0, 220);
        y  = 30 + $urandom_range(0, 120);
        drive_px(x, y, sx);
        sb.push_back(predict(x, y, sx));
        @(posedge Clk); #1;
        e = sb.pop_front(); n_cmp++;
        if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
          n_err++;
          $display("FAIL random[%0d] px=(%0d,%0d) sx=%0d: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
                   k, x, y, sx, bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
        end
      end
    end
  endtask

  task automatic test_respawn();
    exp_t e;
    do_reset();
    wr(0, 50, 50);
    collect(0);
    for (int step = 0; step < 2; step++) begin
`ifdef SPRITE_RESPAWN_EN
      if (step == 0) begin repeat (2) tick(); sb.push_back(mk_exp(1'b0, 0, 0)); end
      else begin tick(); sb.push_back(mk_exp(1'b1, 0, 0)); end
`else
      if (step == 0) begin repeat (3) tick(); end
      else begin repeat (997) tick(); end
      sb.push_back(mk_exp(1'b0, 0, 0));
`endif
      drive_px(50, 50, 0);
      @(posedge Clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
        n_err++;
        $display("FAIL respawn[%0d]: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
                 step, bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    do_reset();
    wr(2, 100, 100);
    repeat (4) tick();
    drive_px(100, 100, 0);
    sb.push_back(mk_exp(1'b1, 2, 1024));
    @(posedge Clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
      n_err++;
      $display("FAIL mid_reset_pre: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
               bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
    end
    @(posedge Clk); #2;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.sprite_hit !== 1'b0 || bus.sprite_id !== 4'd0 || bus.sprite_addr !== 19'd0 || bus.anim_frame !== 3'd0) begin
      n_err++;
      $display("FAIL mid_reset_async: got hit=%b id=%0d addr=%0d frame=%0d, want all 0",
               bus.sprite_hit, bus.sprite_id, bus.sprite_addr, bus.anim_frame);
    end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    drive_px(100, 100, 0);
    sb.push_back(predict(100, 100, 0));
    @(posedge Clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (bus.sprite_hit !== e.hit || bus.sprite_id !== e.id || bus.sprite_addr !== e.addr) begin
      n_err++;
      $display("FAIL mid_reset_post: got hit=%b id=%0d addr=%0d, want hit=%b id=%0d addr=%0d",
               bus.sprite_hit, bus.sprite_id, bus.sprite_addr, e.hit, e.id, e.addr);
    end
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_sprite();
    test_scroll();
    test_priority_collect();
    test_anim();
    test_back_to_back();
    test_random();
    test_respawn();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
